// File: rtl/data_ram_mp.sv
// data_ram_mp: multi-port synchronous data RAM for the LSU/MEM stage.
// Each port does a byte-masked write or a full-word read per cycle.
// Same word + same lane write collisions resolve to the highest port.
// Read latency is 1 or 2 registered stages. rvalid is per port.
// wr_conflict pulses when two ports wrote one word in the previous cycle.
// Optional macro DATA_RAM_BYPASS_EN: reads see same-cycle writes.
// When the macro is undefined, reads return the old contents.
module data_ram_mp #(
    parameter int NUM_PORTS    = 2,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int DEPTH_LOG2   = 10,
    parameter int READ_LATENCY = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_PORTS-1:0]             ce,
    input  logic [NUM_PORTS-1:0]             we,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  addr,
    input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] sel,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  wdata,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]  rdata,
    output logic [NUM_PORTS-1:0]             rvalid,
    output logic                             wr_conflict
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int OFS   = $clog2(NB);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    // Per-port views of the flat port buses
    logic [NUM_PORTS-1:0][DEPTH_LOG2-1:0] idx;
    logic [NUM_PORTS-1:0][NB-1:0]         sel_p;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] wdata_p;
    logic [NUM_PORTS-1:0]                 wr_en;
    logic [NUM_PORTS-1:0]                 rd_en;

    // Byte storage; contents survive reset and start undefined
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Read word per port before the stage-1 register
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rd_word;

    // Stage-1 read pipeline and collision flag
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rdata_s1_d, rdata_s1_q;
    logic [NUM_PORTS-1:0]                 rvalid_s1_d, rvalid_s1_q;
    logic                                 wr_conflict_d, wr_conflict_q;

    // Only the word-index bits of addr are used. The rest wrap or are byte offset.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr;

    // Slice the flat buses and decode per-port read and write enables.
    // Writes are gated by rst so that nothing lands while in reset.
    always_comb begin
        idx     = '0;
        sel_p   = '0;
        wdata_p = '0;
        wr_en   = '0;
        rd_en   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx[i]     = addr[i*ADDR_WIDTH+OFS +: DEPTH_LOG2];
            sel_p[i]   = sel[i*NB +: NB];
            wdata_p[i] = wdata[i*DATA_WIDTH +: DATA_WIDTH];
            wr_en[i]   = ce[i] & we[i] & ~rst;
            rd_en[i]   = ce[i] & ~we[i];
        end
    end

    // Byte-lane memory write.
    // Ports are walked in ascending order, so the highest port wins a shared lane.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            for (int b = 0; b < NB; b++) begin
                if (wr_en[p] && sel_p[p][b]) begin
                    mem_q[idx[p]][b*8 +: 8] <= wdata_p[p][b*8 +: 8];
                end
            end
        end
    end

    // Array read. With bypass, same-cycle writes are overlaid with the same lane priority.
    always_comb begin
        rd_word = '0;
        for (int r = 0; r < NUM_PORTS; r++) begin
            rd_word[r] = mem_q[idx[r]];
`ifdef DATA_RAM_BYPASS_EN
            for (int w = 0; w < NUM_PORTS; w++) begin
                for (int b = 0; b < NB; b++) begin
                    if (wr_en[w] && (idx[w] == idx[r]) && sel_p[w][b]) begin
                        rd_word[r][b*8 +: 8] = wdata_p[w][b*8 +: 8];
                    end
                end
            end
`endif
        end
    end

    // Stage-1 next state. Idle or write slots carry zero data and no valid.
    always_comb begin
        rdata_s1_d  = '0;
        rvalid_s1_d = '0;
        for (int r = 0; r < NUM_PORTS; r++) begin
            if (rd_en[r]) begin
                rdata_s1_d[r]  = rd_word[r];
                rvalid_s1_d[r] = 1'b1;
            end
        end
    end

    // Collision detect: any two writing ports on one word index, whatever their sel.
    always_comb begin
        wr_conflict_d = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            for (int j = i + 1; j < NUM_PORTS; j++) begin
                if (wr_en[i] && wr_en[j] && (idx[i] == idx[j])) begin
                    wr_conflict_d = 1'b1;
                end
            end
        end
    end

    // Stage-1 registers and the conflict pulse, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_s1_q    <= '0;
            rvalid_s1_q   <= '0;
            wr_conflict_q <= 1'b0;
        end else begin
            rdata_s1_q    <= rdata_s1_d;
            rvalid_s1_q   <= rvalid_s1_d;
            wr_conflict_q <= wr_conflict_d;
        end
    end

    assign wr_conflict = wr_conflict_q;

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rdata_s2_d, rdata_s2_q;
            logic [NUM_PORTS-1:0]                 rvalid_s2_d, rvalid_s2_q;

            // Extra stage is a plain delay of stage 1, so it never stalls
            always_comb begin
                rdata_s2_d  = rdata_s1_q;
                rvalid_s2_d = rvalid_s1_q;
            end

            // Stage-2 registers. Reset drops any read still in flight.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata_s2_q  <= '0;
                    rvalid_s2_q <= '0;
                end else begin
                    rdata_s2_q  <= rdata_s2_d;
                    rvalid_s2_q <= rvalid_s2_d;
                end
            end

            assign rdata  = rdata_s2_q;
            assign rvalid = rvalid_s2_q;
        end else begin : g_lat1
            assign rdata  = rdata_s1_q;
            assign rvalid = rvalid_s1_q;
        end
    endgenerate

endmodule

// File: tb/tb_data_ram_mp.sv
// Directed testbench for data_ram_mp.
// dut: 2 ports, latency 1. dut2: 1 port, latency 2.
module tb_data_ram_mp;

    logic        clk;
    logic        rst;
    logic [1:0]  ce, we;
    logic [63:0] addr;
    logic [7:0]  sel;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic [1:0]  rvalid;
    logic        wr_conflict;

    logic        ce2, we2;
    logic [31:0] addr2;
    logic [3:0]  sel2;
    logic [31:0] wdata2;
    logic [31:0] rdata2;
    logic        rvalid2;
    logic        wr_conflict2;

    int checks = 0;
    int errors = 0;

    data_ram_mp #(.NUM_PORTS(2), .DATA_WIDTH(32), .ADDR_WIDTH(32),
                  .DEPTH_LOG2(10), .READ_LATENCY(1)) dut (
        .clk(clk), .rst(rst), .ce(ce), .we(we), .addr(addr), .sel(sel),
        .wdata(wdata), .rdata(rdata), .rvalid(rvalid), .wr_conflict(wr_conflict)
    );

    data_ram_mp #(.NUM_PORTS(1), .DATA_WIDTH(32), .ADDR_WIDTH(32),
                  .DEPTH_LOG2(10), .READ_LATENCY(2)) dut2 (
        .clk(clk), .rst(rst), .ce(ce2), .we(we2), .addr(addr2), .sel(sel2),
        .wdata(wdata2), .rdata(rdata2), .rvalid(rvalid2), .wr_conflict(wr_conflict2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1ns after an edge. Outputs are sampled 1ns after the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ce = '0; we = '0; addr = '0; sel = '0; wdata = '0;
    endtask

    task automatic drv_wr(input int p, input logic [31:0] a, input logic [3:0] s,
                          input logic [31:0] d);
        ce[p] = 1'b1; we[p] = 1'b1;
        addr[p*32 +: 32] = a; sel[p*4 +: 4] = s; wdata[p*32 +: 32] = d;
    endtask

    task automatic drv_rd(input int p, input logic [31:0] a);
        ce[p] = 1'b1; we[p] = 1'b0;
        addr[p*32 +: 32] = a; sel[p*4 +: 4] = 4'h0; wdata[p*32 +: 32] = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        tick();
        tick();
        checks++; if (rdata !== 64'h0) begin errors++; $display("FAIL reset_rdata got %h exp %h", rdata, 64'h0); end
        checks++; if (rvalid !== 2'b00) begin errors++; $display("FAIL reset_rvalid got %b exp %b", rvalid, 2'b00); end
        checks++; if (wr_conflict !== 1'b0) begin errors++; $display("FAIL reset_conflict got %b exp 0", wr_conflict); end
        checks++; if (rvalid2 !== 1'b0 || rdata2 !== 32'h0) begin errors++; $display("FAIL reset_lat2 got %b/%h exp 0/0", rvalid2, rdata2); end
        rst = 1'b0;
    endtask

    task automatic test_write_read();
        idle(); drv_wr(0, 32'h10, 4'hF, 32'hDEADBEEF);
        tick();
        checks++; if (wr_conflict !== 1'b0) begin errors++; $display("FAIL wr_single_conflict got %b exp 0", wr_conflict); end
        idle(); drv_rd(1, 32'h10);
        tick();
        checks++; if (rvalid !== 2'b10) begin errors++; $display("FAIL rd_rvalid got %b exp %b", rvalid, 2'b10); end
        checks++; if (rdata[63:32] !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data1 got %h exp %h", rdata[63:32], 32'hDEADBEEF); end
        checks++; if (rdata[31:0] !== 32'h0) begin errors++; $display("FAIL rd_idle_data0 got %h exp 0", rdata[31:0]); end
        idle();
    endtask

    task automatic test_collision();
        idle(); drv_wr(0, 32'h20, 4'hF, 32'hC0C0C0C0);
        tick();
        idle();
        drv_wr(0, 32'h20, 4'b0011, 32'h11112222);
        drv_wr(1, 32'h20, 4'b0110, 32'h33334444);
        tick();
        checks++; if (wr_conflict !== 1'b1) begin errors++; $display("FAIL coll_flag got %b exp 1", wr_conflict); end
        idle(); drv_rd(0, 32'h20);
        tick();
        checks++; if (wr_conflict !== 1'b0) begin errors++; $display("FAIL coll_pulse_len got %b exp 0", wr_conflict); end
        checks++; if (rdata[31:0] !== 32'hC0334422) begin errors++; $display("FAIL coll_merge got %h exp %h", rdata[31:0], 32'hC0334422); end
        checks++; if (rvalid !== 2'b01) begin errors++; $display("FAIL coll_rvalid got %b exp %b", rvalid, 2'b01); end
        // Different words: no conflict
        idle();
        drv_wr(0, 32'h40, 4'hF, 32'h01010101);
        drv_wr(1, 32'h44, 4'hF, 32'h02020202);
        tick();
        checks++; if (wr_conflict !== 1'b0) begin errors++; $display("FAIL coll_disjoint_words got %b exp 0", wr_conflict); end
        // Same word via different byte offsets and disjoint lanes: conflict, both land
        idle();
        drv_wr(0, 32'h40, 4'b0001, 32'h000000AA);
        drv_wr(1, 32'h42, 4'b1000, 32'hBB000000);
        tick();
        checks++; if (wr_conflict !== 1'b1) begin errors++; $display("FAIL coll_disjoint_lanes got %b exp 1", wr_conflict); end
        idle(); drv_rd(0, 32'h40); drv_rd(1, 32'h44);
        tick();
        checks++; if (rdata[31:0] !== 32'hBB0101AA) begin errors++; $display("FAIL merge_lanes got %h exp %h", rdata[31:0], 32'hBB0101AA); end
        checks++; if (rdata[63:32] !== 32'h02020202) begin errors++; $display("FAIL merge_other got %h exp %h", rdata[63:32], 32'h02020202); end
        checks++; if (rvalid !== 2'b11) begin errors++; $display("FAIL dual_rvalid got %b exp %b", rvalid, 2'b11); end
        idle();
    endtask

    task automatic test_read_during_write();
        logic [31:0] exp_rdw;
`ifdef DATA_RAM_BYPASS_EN
        exp_rdw = 32'h55555555;
`else
        exp_rdw = 32'hAAAAAAAA;
`endif
        idle(); drv_wr(0, 32'h30, 4'hF, 32'hAAAAAAAA);
        tick();
        idle(); drv_wr(0, 32'h30, 4'hF, 32'h55555555); drv_rd(1, 32'h30);
        tick();
        checks++; if (rdata[63:32] !== exp_rdw) begin errors++; $display("FAIL rdw_data got %h exp %h", rdata[63:32], exp_rdw); end
        checks++; if (rvalid !== 2'b10) begin errors++; $display("FAIL rdw_rvalid got %b exp %b", rvalid, 2'b10); end
        checks++; if (rdata[31:0] !== 32'h0) begin errors++; $display("FAIL rdw_write_slot got %h exp 0", rdata[31:0]); end
        // A write with sel==0 must leave the word unchanged
        idle(); drv_wr(0, 32'h30, 4'h0, 32'hFFFFFFFF);
        tick();
        idle(); drv_rd(1, 32'h30);
        tick();
        checks++; if (rdata[63:32] !== 32'h55555555) begin errors++; $display("FAIL sel0_noop got %h exp %h", rdata[63:32], 32'h55555555); end
        idle();
    endtask

    task automatic test_wrap();
        idle(); drv_wr(0, 32'h1000, 4'hF, 32'h12345678);
        tick();
        idle(); drv_rd(1, 32'h0000); drv_rd(0, 32'h2001);
        tick();
        checks++; if (rdata[63:32] !== 32'h12345678) begin errors++; $display("FAIL wrap_p1 got %h exp %h", rdata[63:32], 32'h12345678); end
        checks++; if (rdata[31:0] !== 32'h12345678) begin errors++; $display("FAIL wrap_p0 got %h exp %h", rdata[31:0], 32'h12345678); end
        idle();
        tick();
        checks++; if (rvalid !== 2'b00) begin errors++; $display("FAIL ce0_rvalid got %b exp %b", rvalid, 2'b00); end
        checks++; if (rdata !== 64'h0) begin errors++; $display("FAIL ce0_rdata got %h exp 0", rdata); end
    endtask

    task automatic test_back_to_back();
        ce2 = 1'b1; we2 = 1'b1; sel2 = 4'hF;
        addr2 = 32'h0; wdata2 = 32'hA0A0A0A0; tick();
        addr2 = 32'h4; wdata2 = 32'hB4B4B4B4; tick();
        addr2 = 32'h8; wdata2 = 32'hC8C8C8C8; tick();
        we2 = 1'b0; sel2 = 4'h0; wdata2 = '0; addr2 = 32'h0;
        tick();
        checks++; if (rvalid2 !== 1'b0) begin errors++; $display("FAIL b2b_early got %b exp 0", rvalid2); end
        addr2 = 32'h4;
        tick();
        checks++; if (rvalid2 !== 1'b1 || rdata2 !== 32'hA0A0A0A0) begin errors++; $display("FAIL b2b_0 got %b/%h exp 1/%h", rvalid2, rdata2, 32'hA0A0A0A0); end
        addr2 = 32'h8;
        tick();
        checks++; if (rvalid2 !== 1'b1 || rdata2 !== 32'hB4B4B4B4) begin errors++; $display("FAIL b2b_1 got %b/%h exp 1/%h", rvalid2, rdata2, 32'hB4B4B4B4); end
        ce2 = 1'b0; addr2 = '0;
        tick();
        checks++; if (rvalid2 !== 1'b1 || rdata2 !== 32'hC8C8C8C8) begin errors++; $display("FAIL b2b_2 got %b/%h exp 1/%h", rvalid2, rdata2, 32'hC8C8C8C8); end
        tick();
        checks++; if (rvalid2 !== 1'b0 || rdata2 !== 32'h0) begin errors++; $display("FAIL b2b_tail got %b/%h exp 0/0", rvalid2, rdata2); end
    endtask

    task automatic test_reset_inflight();
        // Latency-1 read presented on a reset edge is dropped
        idle(); drv_rd(0, 32'h10); rst = 1'b1;
        tick();
        checks++; if (rvalid !== 2'b00 || rdata !== 64'h0) begin errors++; $display("FAIL rst_lat1 got %b/%h exp 0/0", rvalid, rdata); end
        rst = 1'b0; idle();
        // Latency-2 read in flight when reset arrives is dropped
        ce2 = 1'b1; we2 = 1'b0; addr2 = 32'h0;
        tick();
        ce2 = 1'b0; rst = 1'b1;
        drv_wr(0, 32'h10, 4'hF, 32'h00000000);
        tick();
        checks++; if (rvalid2 !== 1'b0 || rdata2 !== 32'h0) begin errors++; $display("FAIL rst_lat2_a got %b/%h exp 0/0", rvalid2, rdata2); end
        rst = 1'b0; idle();
        tick();
        checks++; if (rvalid2 !== 1'b0 || rdata2 !== 32'h0) begin errors++; $display("FAIL rst_lat2_b got %b/%h exp 0/0", rvalid2, rdata2); end
        // Pre-reset data retained and the write issued in reset was suppressed
        drv_rd(0, 32'h10); ce2 = 1'b1; addr2 = 32'h0;
        tick();
        checks++; if (rdata[31:0] !== 32'hDEADBEEF || rvalid !== 2'b01) begin errors++; $display("FAIL rst_retain got %b/%h exp 01/%h", rvalid, rdata[31:0], 32'hDEADBEEF); end
        idle(); ce2 = 1'b0;
        tick();
        checks++; if (rvalid2 !== 1'b1 || rdata2 !== 32'hA0A0A0A0) begin errors++; $display("FAIL rst_retain2 got %b/%h exp 1/%h", rvalid2, rdata2, 32'hA0A0A0A0); end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        ce2 = 1'b0; we2 = 1'b0; addr2 = '0; sel2 = '0; wdata2 = '0;
        test_reset();
        test_write_read();
        test_collision();
        test_read_during_write();
        test_wrap();
        test_back_to_back();
        test_reset_inflight();
        checks++; if (wr_conflict2 !== 1'b0) begin errors++; $display("FAIL single_port_conflict got %b exp 0", wr_conflict2); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_ram_mp.md
Name: data_ram_mp

Overview:
Parametrised multi-port synchronous data RAM for the LSU/MEM stage. It is the successor to the fixed 2-port, 32-bit data memory. NUM_PORTS independent ports each perform a byte-masked write or a word read per cycle, with deterministic write-collision priority, configurable read latency (1 or 2), per-port read-valid, and a collision flag.

Parameters:
NUM_PORTS, 2, number of independent read/write ports (1..4)
DATA_WIDTH, 32, word width in bits; multiple of 8; power of two (32 or 64)
ADDR_WIDTH, 32, byte address width per port
DEPTH_LOG2, 10, log2 of word count
READ_LATENCY, 1, cycles from read request to rdata/rvalid; legal values 1 or 2

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
ce  input  NUM_PORTS  per-port chip enable; bit i = port i
we  input  NUM_PORTS  per-port write enable; qualified by ce
addr  input  NUM_PORTS*ADDR_WIDTH  byte addresses; port i in slice [i*ADDR_WIDTH +: ADDR_WIDTH]
sel  input  NUM_PORTS*DATA_WIDTH/8  byte-lane enables; bit 0 = bits [7:0]
wdata  input  NUM_PORTS*DATA_WIDTH  write data
rdata  output  NUM_PORTS*DATA_WIDTH  read data
rvalid  output  NUM_PORTS  1 when the matching rdata slice holds a completed read
wr_conflict  output  1  registered pulse: two or more ports wrote the same word in the previous cycle

Behaviour:
- OFS = log2(DATA_WIDTH/8). Word index = addr[DEPTH_LOG2+OFS-1 : OFS]. Upper address bits are ignored, so the address wraps modulo depth. Low OFS bits are ignored for indexing.
- Storage is DATA_WIDTH/8 byte lanes × 2^DEPTH_LOG2 entries. It is not cleared by rst; contents are X until written.
- Write, when ce[i]&we[i]: each lane with sel set updates at the clk edge. Lanes with sel clear are untouched. sel==0 is a legal no-op write.
- Collision: for the same word and same lane, the highest-numbered port wins. Lanes written by only one port take that port's data, so merged writes from different ports to disjoint lanes both land.
- wr_conflict is 1 in the cycle after any two ports both write the same word index, regardless of sel overlap. Otherwise 0.
- Read, when ce[i]&~we[i]: sel is ignored and the full word is returned.
  - READ_LATENCY=1: rdata/rvalid are registered at the request edge.
  - READ_LATENCY=2: one extra register stage is added; one request per port per cycle is accepted (fully pipelined, no stall).
- Read-during-write to the same word in the same cycle (any port pair) returns the old contents, except as modified by the optional feature.
- ce[i]=0 or a write cycle: the corresponding pipeline slot carries rdata=0 and rvalid=0.
- Reset: rdata=0, rvalid=0 and wr_conflict=0 on the edge where rst=1. All pipeline stages are cleared, so an in-flight read is dropped and never produces rvalid. Writes presented while rst=1 are suppressed.
- Outputs are driven only from registers; there is no combinational input-to-output path.

Optional Feature:
DATA_RAM_BYPASS_EN:
- Defined: a read whose word index matches any same-cycle write returns the post-write word. Written lanes take the winning port's data per the collision rule; other lanes are old.
- Undefined: read-old semantics, as above.
- Latency and rvalid timing are identical in both builds.

Test Plan:
- Reset, then port0 writes addr 0x10, sel 4'b1111, data 0xDEADBEEF; next cycle port1 reads 0x10 (LAT=1) -> rdata1=0xDEADBEEF, rvalid1=1 one edge after the request.
- Port0 writes 0x20 sel 4'b0011 data 0x11112222 and port1 writes 0x20 sel 4'b0110 data 0x33334444 in the same cycle; then read 0x20 -> 0xXX334422 (port1 wins lane1, unwritten lane3 unchanged); wr_conflict=1 exactly one cycle.
- Word 0x30 holds 0xAAAAAAAA; same cycle port0 writes 0x30 = 0x55555555 and port1 reads 0x30 -> rdata1=0xAAAAAAAA (macro off) or 0x55555555 (DATA_RAM_BYPASS_EN).
- READ_LATENCY=2, back-to-back reads of 0x0, 0x4, 0x8 on port0 -> rvalid0 high on three consecutive cycles starting 2 edges after the first request, data in order.
- Read issued, rst=1 on the next edge -> rvalid stays 0 and rdata=0; memory still holds pre-reset data on a later read.
- DEPTH_LOG2=10: write addr 0x1000, read addr 0x0000 -> same word returned (wrap); ce=0 cycles -> rvalid=0, rdata=0.
